// File: rtl/mem_stage_access_unit.sv
// -----------------------------------------------------------------------------
// mem_stage_access_unit
//
// MEM pipeline stage. Consumes the EXE/MEM register outputs, performs loads
// and stores against an external data memory over a req/ack handshake, and
// produces the MEM/WB register contents for write-back. While an access is
// outstanding the upstream pipeline is held through MemStall.
//
// A word access with addr[1:0] != 0 is squashed and flagged when ALIGN_CHECK
// is set. An access that sees no DMemAck within TIMEOUT_CYCLES cycles is
// aborted and flagged, and its register write is suppressed.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   EXE_MEM_Result      ALU result, also the memory address for loads/stores
//   EXE_MEM_Rt          store data
//   EXE_MEM_DstReg      destination register
//   EXE_MEM_MemRead     load
//   EXE_MEM_MemWrite    store (wins when MemRead is also set)
//   EXE_MEM_MemtoReg    write-back selects memory data
//   EXE_MEM_RegWrite    write-back writes the register file
//   DMemReq/We/Addr/WData   registered request to data memory
//   DMemRData, DMemAck  read data and one-cycle completion pulse
//   MemStall            combinational hold request to PC/IF/ID/EXE and EXE/MEM
//   MEM_WB_*            MEM/WB pipeline register
//   MemAlignErr         one-cycle pulse after a misaligned access
//   MemTimeoutErr       one-cycle pulse after an aborted access
//
// State table
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no access outstanding; ALU ops pass straight to MEM/WB
//   REQ     | DMemReq asserted, waiting for DMemAck or the timeout
//   DONE    | access finished; MEM/WB captures the held op, pipeline moves
// -----------------------------------------------------------------------------
module mem_stage_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter bit          ALIGN_CHECK    = 1'b1
) (
   input  logic        clk,
   input  logic        rst,

   input  logic [31:0] EXE_MEM_Result,
   input  logic [31:0] EXE_MEM_Rt,
   input  logic [4:0]  EXE_MEM_DstReg,
   input  logic        EXE_MEM_MemRead,
   input  logic        EXE_MEM_MemWrite,
   input  logic        EXE_MEM_MemtoReg,
   input  logic        EXE_MEM_RegWrite,

   output logic        DMemReq,
   output logic        DMemWe,
   output logic [31:0] DMemAddr,
   output logic [31:0] DMemWData,
   input  logic [31:0] DMemRData,
   input  logic        DMemAck,

   output logic        MemStall,

   output logic [31:0] MEM_WB_ReadData,
   output logic [31:0] MEM_WB_Result,
   output logic [4:0]  MEM_WB_DstReg,
   output logic        MEM_WB_MemtoReg,
   output logic        MEM_WB_RegWrite,

   output logic        MemAlignErr,
   output logic        MemTimeoutErr
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Counter value on which a still-unacknowledged request is abandoned.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_e      state_q,     state_d;
   logic [7:0]  tmo_cnt_q,   tmo_cnt_d;
   logic        abort_q,     abort_d;

   logic        req_q,       req_d;
   logic        we_q,        we_d;
   logic [31:0] addr_q,      addr_d;
   logic [31:0] wdata_q,     wdata_d;

   logic [31:0] rd_data_q,   rd_data_d;
   logic [31:0] result_q,    result_d;
   logic [4:0]  dst_q,       dst_d;
   logic        m2r_q,       m2r_d;
   logic        rw_q,        rw_d;

   logic        align_err_q, align_err_d;
   logic        tmo_err_q,   tmo_err_d;

   logic        mem_stall;
   logic        memop;
   logic        mis;

   assign memop = EXE_MEM_MemRead | EXE_MEM_MemWrite;
   assign mis   = ALIGN_CHECK && memop && (EXE_MEM_Result[1:0] != 2'b00);

   always_comb begin
      state_d     = state_q;
      tmo_cnt_d   = tmo_cnt_q;
      abort_d     = abort_q;
      req_d       = req_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rd_data_d   = rd_data_q;
      result_d    = result_q;
      dst_d       = dst_q;
      m2r_d       = m2r_q;
      rw_d        = rw_q;
      align_err_d = 1'b0;
      tmo_err_d   = 1'b0;
      mem_stall   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (mis) begin
               // Squashed access: bubble into MEM/WB, no memory traffic.
               rw_d        = 1'b0;
               m2r_d       = 1'b0;
               align_err_d = 1'b1;
            end else if (memop) begin
               mem_stall = 1'b1;
               req_d     = 1'b1;
               we_d      = EXE_MEM_MemWrite;
               addr_d    = {EXE_MEM_Result[31:2], 2'b00};
               wdata_d   = EXE_MEM_Rt;
               tmo_cnt_d = 8'd0;
               rw_d      = 1'b0;
               m2r_d     = 1'b0;
               state_d   = ST_REQ;
            end else begin
               result_d = EXE_MEM_Result;
               dst_d    = EXE_MEM_DstReg;
               m2r_d    = EXE_MEM_MemtoReg;
               rw_d     = EXE_MEM_RegWrite;
            end
         end

         ST_REQ: begin
            mem_stall = 1'b1;
            rw_d      = 1'b0;
            m2r_d     = 1'b0;
            if (DMemAck) begin
               // we_q is clear only for pure loads; stores leave ReadData alone.
               if (!we_q) begin
                  rd_data_d = DMemRData;
               end
               req_d   = 1'b0;
               state_d = ST_DONE;
            end else if (tmo_cnt_q == TMO_LAST) begin
               req_d     = 1'b0;
               tmo_err_d = 1'b1;
               abort_d   = 1'b1;
               state_d   = ST_DONE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 8'd1;
            end
         end

         ST_DONE: begin
            // The op is still on the EXE/MEM inputs; capture it now while the
            // pipeline advances. Returning to IDLE on the same edge keeps it
            // from being issued a second time.
            result_d = EXE_MEM_Result;
            dst_d    = EXE_MEM_DstReg;
            m2r_d    = EXE_MEM_MemtoReg;
            rw_d     = EXE_MEM_RegWrite & ~EXE_MEM_MemWrite & ~abort_q;
            abort_d  = 1'b0;
            state_d  = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         tmo_cnt_q   <= 8'd0;
         abort_q     <= 1'b0;
         req_q       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         rd_data_q   <= 32'd0;
         result_q    <= 32'd0;
         dst_q       <= 5'd0;
         m2r_q       <= 1'b0;
         rw_q        <= 1'b0;
         align_err_q <= 1'b0;
         tmo_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         tmo_cnt_q   <= tmo_cnt_d;
         abort_q     <= abort_d;
         req_q       <= req_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rd_data_q   <= rd_data_d;
         result_q    <= result_d;
         dst_q       <= dst_d;
         m2r_q       <= m2r_d;
         rw_q        <= rw_d;
         align_err_q <= align_err_d;
         tmo_err_q   <= tmo_err_d;
      end
   end

   assign DMemReq         = req_q;
   assign DMemWe          = we_q;
   assign DMemAddr        = addr_q;
   assign DMemWData       = wdata_q;
   assign MemStall        = mem_stall;
   assign MEM_WB_ReadData = rd_data_q;
   assign MEM_WB_Result   = result_q;
   assign MEM_WB_DstReg   = dst_q;
   assign MEM_WB_MemtoReg = m2r_q;
   assign MEM_WB_RegWrite = rw_q;
   assign MemAlignErr     = align_err_q;
   assign MemTimeoutErr   = tmo_err_q;

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_access_unit
//
// Drives mem_stage_access_unit as an in-order pipeline would: a new EXE/MEM op
// is presented only after a cycle in which MemStall was low. The bench plays
// the data memory, choosing on which REQ cycle (if any) DMemAck arrives, and
// predicts every MEM/WB and memory-port value per transaction.
// -----------------------------------------------------------------------------
module tb_mem_stage_access_unit;

   localparam int TMO = 4;

   logic        clk;
   logic        rst;
   logic [31:0] EXE_MEM_Result;
   logic [31:0] EXE_MEM_Rt;
   logic [4:0]  EXE_MEM_DstReg;
   logic        EXE_MEM_MemRead;
   logic        EXE_MEM_MemWrite;
   logic        EXE_MEM_MemtoReg;
   logic        EXE_MEM_RegWrite;
   logic        DMemReq;
   logic        DMemWe;
   logic [31:0] DMemAddr;
   logic [31:0] DMemWData;
   logic [31:0] DMemRData;
   logic        DMemAck;
   logic        MemStall;
   logic [31:0] MEM_WB_ReadData;
   logic [31:0] MEM_WB_Result;
   logic [4:0]  MEM_WB_DstReg;
   logic        MEM_WB_MemtoReg;
   logic        MEM_WB_RegWrite;
   logic        MemAlignErr;
   logic        MemTimeoutErr;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // Last value the load path delivered; MEM_WB_ReadData must always show it.
   logic [31:0] exp_rd;

   mem_stage_access_unit #(
      .TIMEOUT_CYCLES (TMO),
      .ALIGN_CHECK    (1'b1)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .EXE_MEM_Result   (EXE_MEM_Result),
      .EXE_MEM_Rt       (EXE_MEM_Rt),
      .EXE_MEM_DstReg   (EXE_MEM_DstReg),
      .EXE_MEM_MemRead  (EXE_MEM_MemRead),
      .EXE_MEM_MemWrite (EXE_MEM_MemWrite),
      .EXE_MEM_MemtoReg (EXE_MEM_MemtoReg),
      .EXE_MEM_RegWrite (EXE_MEM_RegWrite),
      .DMemReq          (DMemReq),
      .DMemWe           (DMemWe),
      .DMemAddr         (DMemAddr),
      .DMemWData        (DMemWData),
      .DMemRData        (DMemRData),
      .DMemAck          (DMemAck),
      .MemStall         (MemStall),
      .MEM_WB_ReadData  (MEM_WB_ReadData),
      .MEM_WB_Result    (MEM_WB_Result),
      .MEM_WB_DstReg    (MEM_WB_DstReg),
      .MEM_WB_MemtoReg  (MEM_WB_MemtoReg),
      .MEM_WB_RegWrite  (MEM_WB_RegWrite),
      .MemAlignErr      (MemAlignErr),
      .MemTimeoutErr    (MemTimeoutErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // One instruction through MEM. Called at posedge+1. ack_at is the REQ cycle
   // (1-based) on which memory acknowledges; 0 or anything past TMO never acks.
   // junk_ack puts a stray ack on the bus outside REQ, which must be ignored.
   task automatic run_op(input logic [31:0] res, input logic [31:0] rt,
                         input logic [4:0] dst, input logic mr, input logic mw,
                         input logic m2r, input logic rw, input int ack_at,
                         input logic [31:0] rdata, input bit junk_ack);
      bit memop, mis, store, tmo;
      int exp_len, cnt;
      memop = mr | mw;
      mis   = memop && (res[1:0] != 2'b00);
      store = mw;

      EXE_MEM_Result   = res;
      EXE_MEM_Rt       = rt;
      EXE_MEM_DstReg   = dst;
      EXE_MEM_MemRead  = mr;
      EXE_MEM_MemWrite = mw;
      EXE_MEM_MemtoReg = m2r;
      EXE_MEM_RegWrite = rw;
      DMemAck          = 1'b0;
      if (junk_ack && !memop) begin
         DMemAck   = 1'b1;
         DMemRData = $urandom;
      end
      #1;
      chk1("stall_idle", MemStall, memop && !mis);
      @(posedge clk); #1;
      DMemAck = 1'b0;

      if (!memop || mis) begin
         chk1("req_idle", DMemReq, 1'b0);
         chk1("align_err", MemAlignErr, mis);
         chk1("wb_regwrite_alu", MEM_WB_RegWrite, mis ? 1'b0 : rw);
         chk1("wb_memtoreg_alu", MEM_WB_MemtoReg, mis ? 1'b0 : m2r);
         chk32("wb_readdata_alu", MEM_WB_ReadData, exp_rd);
         if (!mis) begin
            chk32("wb_result_alu", MEM_WB_Result, res);
            chk32("wb_dst_alu", 32'(MEM_WB_DstReg), 32'(dst));
         end
         return;
      end

      if (ack_at >= 1 && ack_at <= TMO) begin
         exp_len = ack_at;
         tmo     = 1'b0;
      end else begin
         exp_len = TMO;
         tmo     = 1'b1;
      end

      chk1("align_err_mem", MemAlignErr, 1'b0);
      cnt = 0;
      while (DMemReq === 1'b1 && cnt < 40) begin
         cnt++;
         chk32("dmem_addr", DMemAddr, {res[31:2], 2'b00});
         chk1("dmem_we", DMemWe, store);
         chk32("dmem_wdata", DMemWData, rt);
         chk1("stall_req", MemStall, 1'b1);
         chk1("wb_bubble_req", MEM_WB_RegWrite, 1'b0);
         if (cnt == ack_at) begin
            DMemAck   = 1'b1;
            DMemRData = rdata;
         end
         @(posedge clk); #1;
         DMemAck = 1'b0;
      end
      if (!tmo && !store) exp_rd = rdata;

      chk32("req_len", 32'(cnt), 32'(exp_len));
      chk1("tmo_err_done", MemTimeoutErr, tmo);
      chk1("stall_done", MemStall, 1'b0);
      chk32("rd_done", MEM_WB_ReadData, exp_rd);
      if (junk_ack) begin
         DMemAck   = 1'b1;
         DMemRData = ~rdata;
      end
      @(posedge clk); #1;
      DMemAck = 1'b0;

      chk32("wb_result_mem", MEM_WB_Result, res);
      chk32("wb_dst_mem", 32'(MEM_WB_DstReg), 32'(dst));
      chk1("wb_memtoreg_mem", MEM_WB_MemtoReg, m2r);
      chk1("wb_regwrite_mem", MEM_WB_RegWrite, rw && !store && !tmo);
      chk32("wb_readdata_mem", MEM_WB_ReadData, exp_rd);
      chk1("tmo_err_after", MemTimeoutErr, 1'b0);
      chk1("req_after", DMemReq, 1'b0);
   endtask

   initial begin
      logic [31:0] r_res, r_rt, r_rd;
      logic [4:0]  r_dst;
      logic        r_mr, r_mw;
      int          kind;

      exp_rd = 32'd0;

      // Reset held for two edges while the inputs already present a load.
      rst              = 1'b1;
      EXE_MEM_Result   = 32'h0000_0300;
      EXE_MEM_Rt       = 32'h5555_AAAA;
      EXE_MEM_DstReg   = 5'd7;
      EXE_MEM_MemRead  = 1'b1;
      EXE_MEM_MemWrite = 1'b0;
      EXE_MEM_MemtoReg = 1'b1;
      EXE_MEM_RegWrite = 1'b1;
      DMemAck          = 1'b0;
      DMemRData        = 32'd0;
      @(posedge clk); #1;
      chk1("rst_req", DMemReq, 1'b0);
      chk1("rst_we", DMemWe, 1'b0);
      chk32("rst_addr", DMemAddr, 32'd0);
      chk32("rst_wdata", DMemWData, 32'd0);
      chk32("rst_readdata", MEM_WB_ReadData, 32'd0);
      chk32("rst_result", MEM_WB_Result, 32'd0);
      chk32("rst_dst", 32'(MEM_WB_DstReg), 32'd0);
      chk1("rst_memtoreg", MEM_WB_MemtoReg, 1'b0);
      chk1("rst_regwrite", MEM_WB_RegWrite, 1'b0);
      chk1("rst_align_err", MemAlignErr, 1'b0);
      chk1("rst_tmo_err", MemTimeoutErr, 1'b0);
      @(posedge clk); #1;
      chk1("rst2_req", DMemReq, 1'b0);
      chk1("rst2_regwrite", MEM_WB_RegWrite, 1'b0);
      rst = 1'b0;
      #1;
      chk1("stall_after_rst", MemStall, 1'b1);
      @(negedge clk);
      @(posedge clk); #1;
      // The load that was waiting out reset has now issued; finish it by hand.
      chk1("rst_load_req", DMemReq, 1'b1);
      chk32("rst_load_addr", DMemAddr, 32'h0000_0300);
      DMemAck   = 1'b1;
      DMemRData = 32'h0BAD_BEEF;
      @(posedge clk); #1;
      DMemAck = 1'b0;
      exp_rd  = 32'h0BAD_BEEF;
      chk1("rst_load_done_req", DMemReq, 1'b0);
      chk32("rst_load_rd", MEM_WB_ReadData, exp_rd);
      @(posedge clk); #1;
      chk1("rst_load_regwrite", MEM_WB_RegWrite, 1'b1);

      // Directed cases.
      run_op(32'h0000_0042, 32'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 0, 32'd0, 1'b0);
      run_op(32'h0000_0100, 32'h1111_2222, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 2,
             32'hCAFE_F00D, 1'b0);
      run_op(32'h0000_0204, 32'h1234_5678, 5'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1,
             32'hDEAD_0000, 1'b0);
      run_op(32'h0000_0102, 32'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1,
             32'h7777_7777, 1'b0);
      run_op(32'h0000_0300, 32'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 0,
             32'h3333_3333, 1'b0);
      run_op(32'h0000_0400, 32'hABCD_0123, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1, 3,
             32'h4444_4444, 1'b1);
      run_op(32'h0000_0044, 32'd0, 5'd10, 1'b0, 1'b0, 1'b1, 1'b1, 0, 32'd0, 1'b1);

      // Randomised mix of ALU ops, loads, stores, load+store and misaligned ops.
      for (int i = 0; i < 60; i++) begin
         kind  = $urandom_range(0, 4);
         r_res = $urandom;
         r_rt  = $urandom;
         r_rd  = $urandom;
         r_dst = 5'($urandom_range(0, 31));
         r_mr  = 1'b0;
         r_mw  = 1'b0;
         case (kind)
            1: r_mr = 1'b1;
            2: r_mw = 1'b1;
            3: begin r_mr = 1'b1; r_mw = 1'b1; end
            4: begin r_mr = 1'($urandom_range(0, 1)); r_mw = ~r_mr; end
            default: ;
         endcase
         if (kind == 4) r_res[1:0] = 2'($urandom_range(1, 3));
         else if (kind != 0) r_res[1:0] = 2'b00;
         run_op(r_res, r_rt, r_dst, r_mr, r_mw, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, TMO + 1), r_rd,
                1'($urandom_range(0, 1)));
      end

      // Reset while a request is outstanding; a late ack must not land.
      EXE_MEM_Result   = 32'h0000_0500;
      EXE_MEM_DstReg   = 5'd11;
      EXE_MEM_MemRead  = 1'b1;
      EXE_MEM_MemWrite = 1'b0;
      EXE_MEM_MemtoReg = 1'b1;
      EXE_MEM_RegWrite = 1'b1;
      #1;
      chk1("midrst_stall", MemStall, 1'b1);
      @(posedge clk); #1;
      chk1("midrst_req1", DMemReq, 1'b1);
      @(posedge clk); #1;
      chk1("midrst_req2", DMemReq, 1'b1);
      rst              = 1'b1;
      EXE_MEM_MemRead  = 1'b0;
      EXE_MEM_MemtoReg = 1'b0;
      EXE_MEM_RegWrite = 1'b0;
      @(posedge clk); #1;
      chk1("midrst_req_drop", DMemReq, 1'b0);
      chk1("midrst_stall_idle", MemStall, 1'b0);
      chk32("midrst_rd", MEM_WB_ReadData, 32'd0);
      rst       = 1'b0;
      DMemAck   = 1'b1;
      DMemRData = 32'hFEED_FACE;
      @(posedge clk); #1;
      DMemAck = 1'b0;
      chk1("late_ack_req", DMemReq, 1'b0);
      chk32("late_ack_rd", MEM_WB_ReadData, 32'd0);
      chk1("late_ack_stall", MemStall, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
